// File: rtl/user_wb_mailbox.sv
// Wishbone classic mailbox slave: register file, CPU->user TX FIFO,
// user->CPU RX FIFO and an RX-pending interrupt.

// Single-clock FIFO slice. The caller guarantees that push only happens
// when not full and pop only happens when not empty. Flush wins over
// same-cycle traffic.
module mbx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;

  // pointers and occupancy; push+pop together leaves count unchanged
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // storage, contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

  assign rdata = mem[rp];
endmodule

module user_wb_mailbox #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter logic [31:0] ID_VALUE = 32'h4D42_0001,
  parameter int          DEPTH    = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TX = 0;
  localparam int RX = 1;

  localparam logic [7:0] OFF_ID      = 8'h00;
  localparam logic [7:0] OFF_CTRL    = 8'h04;
  localparam logic [7:0] OFF_STATUS  = 8'h08;
  localparam logic [7:0] OFF_TXDATA  = 8'h0C;
  localparam logic [7:0] OFF_RXDATA  = 8'h10;
  localparam logic [7:0] OFF_SCRATCH = 8'h14;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  wb_req_t wb;
  assign wb = {wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i};

  logic        en, irq_en, tx_ovf, rx_unf;
  logic [31:0] scratch, rd_data, status;
  logic [7:0]  off;
  logic        req, wr, rd;

  logic [1:0]           f_push, f_pop;
  logic [1:0][31:0]     f_wdata, f_rdata;
  logic [1:0][CW-1:0]   f_cnt;
  logic                 flush;

  // request decode: ack masks the second cycle so each transfer acts once
  assign off = wb.adr[7:0];
  assign req = wb.cyc & wb.stb & (wb.adr[31:8] == BASE_ADR[31:8]) & ~wbs_ack_o;
  assign wr  = req & wb.we;
  assign rd  = req & ~wb.we;

  logic tx_empty, tx_full, rx_empty, rx_full;
  assign tx_empty = (f_cnt[TX] == '0);
  assign tx_full  = (f_cnt[TX] == CW'(DEPTH));
  assign rx_empty = (f_cnt[RX] == '0);
  assign rx_full  = (f_cnt[RX] == CW'(DEPTH));

  // user-side handshakes depend only on registered state
  assign tx_valid = en & ~tx_empty;
  assign tx_data  = f_rdata[TX];
  assign rx_ready = en & ~rx_full;

  logic tx_wr, tx_drop, rx_rd, rx_unf_ev, ctrl_wr, stat_wr, scr_wr;
  assign tx_wr     = wr & (off == OFF_TXDATA);
  assign tx_drop   = tx_wr & tx_full;
  assign rx_rd     = rd & (off == OFF_RXDATA);
  assign rx_unf_ev = rx_rd & rx_empty;
  assign ctrl_wr   = wr & (off == OFF_CTRL) & wb.sel[0];
  assign stat_wr   = wr & (off == OFF_STATUS);
  assign scr_wr    = wr & (off == OFF_SCRATCH);
  assign flush     = ctrl_wr & wb.dat[2];

  assign f_push[TX]  = tx_wr & ~tx_full;
  assign f_pop[TX]   = tx_valid & tx_ready;
  assign f_wdata[TX] = wb.dat;
  assign f_push[RX]  = rx_valid & rx_ready;
  assign f_pop[RX]   = rx_rd & ~rx_empty;
  assign f_wdata[RX] = rx_data;

  for (genvar i = 0; i < 2; i++) begin : g_fifo
    mbx_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .flush (flush),
      .push  (f_push[i]),
      .pop   (f_pop[i]),
      .wdata (f_wdata[i]),
      .rdata (f_rdata[i]),
      .count (f_cnt[i])
    );
  end

  assign status = {8'h00, 8'(f_cnt[TX]), 8'(f_cnt[RX]), 2'b00,
                   rx_unf, tx_ovf, tx_full, tx_empty, rx_full, rx_empty};

  // read mux over pre-edge state
  always_comb begin
    rd_data = '0;
    case (off)
      OFF_ID:      rd_data = ID_VALUE;
      OFF_CTRL:    rd_data = {30'b0, irq_en, en};
      OFF_STATUS:  rd_data = status;
      OFF_RXDATA:  rd_data = rx_empty ? 32'h0 : f_rdata[RX];
      OFF_SCRATCH: rd_data = scratch;
      default:     rd_data = '0;
    endcase
  end

  // bus response, control, scratch and interrupt registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      en        <= 1'b0;
      irq_en    <= 1'b0;
      scratch   <= '0;
      irq       <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      if (req) wbs_dat_o <= wb.we ? 32'h0 : rd_data;
      if (ctrl_wr) begin
        en     <= wb.dat[0];
        irq_en <= wb.dat[1];
      end
      for (int b = 0; b < 4; b++)
        if (scr_wr && wb.sel[b]) scratch[8*b +: 8] <= wb.dat[8*b +: 8];
      irq <= irq_en & en & ~rx_empty;
    end
  end

  // sticky error flags, set wins over a same-cycle clear
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      if (stat_wr && wb.dat[4]) tx_ovf <= 1'b0;
      if (stat_wr && wb.dat[5]) rx_unf <= 1'b0;
      if (tx_drop)   tx_ovf <= 1'b1;
      if (rx_unf_ev) rx_unf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_user_wb_mailbox.sv
// Self-checking bench for user_wb_mailbox: directed steps from the test
// plan followed by a randomized phase checked against a queue-based model.
module tb_user_wb_mailbox;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [31:0] ID    = 32'h4D42_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        irq;

  int checks = 0;
  int errors = 0;

  user_wb_mailbox #(.BASE_ADR(BASE), .ID_VALUE(ID), .DEPTH(DEPTH)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // reference model
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  logic        m_en = 0, m_irq_en = 0, m_tx_ovf = 0, m_rx_unf = 0;
  logic [31:0] m_scratch = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] status_exp();
    int t = tx_q.size();
    int r = rx_q.size();
    logic [31:0] s = '0;
    s[0] = (r == 0);
    s[1] = (r == DEPTH);
    s[2] = (t == 0);
    s[3] = (t == DEPTH);
    s[4] = m_tx_ovf;
    s[5] = m_rx_unf;
    s[15:8]  = 8'(r);
    s[23:16] = 8'(t);
    return s;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] off);
    logic [31:0] r = '0;
    case (off)
      8'h00: r = ID;
      8'h04: r = {30'b0, m_irq_en, m_en};
      8'h08: r = status_exp();
      8'h10: if (rx_q.size() > 0) r = rx_q.pop_front(); else m_rx_unf = 1'b1;
      8'h14: r = m_scratch;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic void model_write(input logic [7:0] off, input logic [31:0] d,
                                      input logic [3:0] s);
    case (off)
      8'h04: if (s[0]) begin
        m_en = d[0];
        m_irq_en = d[1];
        if (d[2]) begin tx_q.delete(); rx_q.delete(); end
      end
      8'h08: begin
        if (d[4]) m_tx_ovf = 1'b0;
        if (d[5]) m_rx_unf = 1'b0;
      end
      8'h0C: if (tx_q.size() < DEPTH) tx_q.push_back(d); else m_tx_ovf = 1'b1;
      8'h14: for (int b = 0; b < 4; b++) if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
      default: ;
    endcase
  endfunction

  // one bus transfer; entered and left at posedge+1
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] got, output int lat);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ack && lat < 5);
    got = rdat;
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    check("ack_drop", 32'(ack), 32'h0);
  endtask

  task automatic op(input logic w, input logic [7:0] off, input logic [31:0] d,
                    input logic [3:0] s, input string tag, output logic [31:0] got);
    logic [31:0] exp;
    int lat;
    exp = w ? 32'h0 : model_read(off);
    xfer(w, BASE | {24'h0, off}, d, s, got, lat);
    check({tag, "_lat"}, 32'(lat), 32'h1);
    if (!w) check(tag, got, exp);
    else model_write(off, d, s);
  endtask

  task automatic rx_push(input logic [31:0] d);
    logic rdy;
    rdy = m_en && (rx_q.size() < DEPTH);
    check("rx_ready", 32'(rx_ready), 32'(rdy));
    rx_valid = 1; rx_data = d;
    @(posedge clk); #1;
    rx_valid = 0;
    if (rdy) rx_q.push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic tx_drain();
    int n = tx_q.size();
    tx_ready = 1;
    for (int i = 0; i < n; i++) begin
      check("drain_valid", 32'(tx_valid), 32'h1);
      check("drain_data", tx_data, tx_q.pop_front());
      @(posedge clk); #1;
    end
    check("drain_empty", 32'(tx_valid), 32'h0);
    tx_ready = 0;
  endtask

  task automatic state_check();
    check("irq", 32'(irq), 32'(m_irq_en && m_en && rx_q.size() != 0));
    check("tx_valid", 32'(tx_valid), 32'(m_en && tx_q.size() != 0));
    check("rx_ready_st", 32'(rx_ready), 32'(m_en && rx_q.size() < DEPTH));
    if (m_en && tx_q.size() != 0) check("tx_head", tx_data, tx_q[0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, d;
    logic        seen;
    int          r;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_dat", rdat, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_txv", 32'(tx_valid), 32'h0);
    check("rst_rxr", 32'(rx_ready), 32'h0);
    rst = 0;

    op(0, 8'h00, 0, 4'hF, "id", got);
    check("id_const", got, 32'h4D42_0001);
    op(0, 8'h08, 0, 4'hF, "status0", got);
    check("status0_const", got, 32'h0000_0005);

    // ack is one cycle long even with stb held
    cyc = 1; stb = 1; we = 0; adr = BASE; sel = 4'hF;
    @(posedge clk); #1;
    check("hold_ack1", 32'(ack), 32'h1);
    check("hold_dat", rdat, ID);
    @(posedge clk); #1;
    check("hold_ack2", 32'(ack), 32'h0);
    cyc = 0; stb = 0;
    @(posedge clk); #1;

    // scratch byte lanes
    op(1, 8'h14, 32'hAABB_CCDD, 4'hF, "scr_w", got);
    op(1, 8'h14, 32'h1122_3344, 4'b0010, "scr_w2", got);
    op(0, 8'h14, 0, 4'hF, "scr_r", got);
    check("scr_const", got, 32'hAABB_33DD);

    // TX overflow and in-order drain
    op(1, 8'h04, 32'h1, 4'hF, "ctrl_en", got);
    for (int i = 0; i < 9; i++) op(1, 8'h0C, $urandom, 4'hF, "txw", got);
    op(0, 8'h08, 0, 4'hF, "status_txfull", got);
    check("status_txfull_const", got, 32'h0008_0019);
    tx_drain();
    op(1, 8'h08, 32'h10, 4'hF, "w1c_ovf", got);
    op(0, 8'h08, 0, 4'hF, "status_w1c", got);
    check("status_w1c_const", got, 32'h0000_0005);

    // RX interrupt timing and underflow
    op(1, 8'h04, 32'h3, 4'hF, "ctrl_irq", got);
    rx_valid = 1; rx_data = 32'h55;
    @(posedge clk); #1;
    rx_valid = 0; rx_q.push_back(32'h55);
    check("irq_n1", 32'(irq), 32'h0);
    @(posedge clk); #1;
    check("irq_n2", 32'(irq), 32'h1);
    op(0, 8'h10, 0, 4'hF, "rx_55", got);
    check("rx_55_const", got, 32'h55);
    check("irq_after_pop", 32'(irq), 32'h0);
    op(0, 8'h10, 0, 4'hF, "rx_unf", got);
    check("rx_unf_const", got, 32'h0);
    op(0, 8'h08, 0, 4'hF, "status_unf", got);
    check("status_unf_bit", 32'(got[5]), 32'h1);

    // full RX FIFO: held rx_valid blocked during pop, accepted next cycle
    for (int i = 0; i < DEPTH; i++) rx_push(32'h100 + i);
    check("rx_full_rdy", 32'(rx_ready), 32'h0);
    rx_valid = 1; rx_data = 32'hCAFE_0001;
    op(0, 8'h10, 0, 4'hF, "rx_full_pop", got);
    rx_valid = 0;
    rx_q.push_back(32'hCAFE_0001);
    op(0, 8'h08, 0, 4'hF, "status_rx8", got);
    check("status_rx8_cnt", 32'(got[15:8]), 32'h8);

    // flush with both FIFOs non-empty
    op(1, 8'h0C, 32'h1234, 4'hF, "txw_f", got);
    op(1, 8'h0C, 32'h5678, 4'hF, "txw_f2", got);
    op(1, 8'h08, 32'h30, 4'hF, "w1c_all", got);
    op(1, 8'h04, 32'h7, 4'hF, "ctrl_flush", got);
    op(0, 8'h08, 0, 4'hF, "status_flush", got);
    check("status_flush_const", got, 32'h0000_0005);
    op(0, 8'h04, 0, 4'hF, "ctrl_rd", got);
    check("ctrl_rd_const", got, 32'h3);

    // outside the window: never acked
    seen = 0;
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h100;
    repeat (4) begin @(posedge clk); #1; seen |= ack; end
    cyc = 0; stb = 0;
    check("no_ack_outside", 32'(seen), 32'h0);
    @(posedge clk); #1;

    // randomized phase
    for (int it = 0; it < 300; it++) begin
      state_check();
      r = $urandom_range(0, 11);
      case (r)
        0, 1: op(1, 8'h0C, $urandom, 4'($urandom_range(0, 15)), "r_txw", got);
        2:    op(0, 8'h10, 0, 4'hF, "r_rxd", got);
        3:    op(0, 8'h08, 0, 4'hF, "r_status", got);
        4:    op(1, 8'h14, $urandom, 4'($urandom_range(0, 15)), "r_scrw", got);
        5:    op(0, 8'h14, 0, 4'hF, "r_scrr", got);
        6, 7: rx_push($urandom);
        8: begin
          d = 32'($urandom_range(0, 3));
          if ($urandom_range(0, 15) == 0) d[2] = 1'b1;
          op(1, 8'h04, d, ($urandom_range(0, 3) == 0) ? 4'hE : 4'hF, "r_ctrl", got);
        end
        9:  op(1, 8'h08, $urandom, 4'hF, "r_w1c", got);
        10: op(0, 8'($urandom_range(0, 7) * 4), 0, 4'hF, "r_rdany", got);
        default: if (m_en) tx_drain();
      endcase
    end

    op(1, 8'h04, 32'h1, 4'hF, "ctrl_end", got);
    tx_drain();

    // reset during a pending request drops it
    op(1, 8'h14, 32'h1234_5678, 4'hF, "scr_pre", got);
    cyc = 1; stb = 1; we = 1; adr = BASE | 32'h14; wdat = 32'hDEAD_BEEF; sel = 4'hF;
    rst = 1;
    @(posedge clk); #1;
    check("rst_mid_ack", 32'(ack), 32'h0);
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    rst = 0;
    tx_q.delete(); rx_q.delete();
    m_en = 0; m_irq_en = 0; m_tx_ovf = 0; m_rx_unf = 0; m_scratch = '0;
    @(posedge clk); #1;
    op(0, 8'h14, 0, 4'hF, "scr_after_rst", got);
    check("scr_after_rst_const", got, 32'h0);
    op(0, 8'h08, 0, 4'hF, "status_after_rst", got);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
